// File: rtl/ifu_fetch_ctrl.sv
// Instruction-fetch controller: owns the PC, issues one word fetch at a time and hands
// each fetched instruction plus its PC to decode; redirects drop any stale in-flight word.
module ifu_fetch_ctrl #(
    parameter int unsigned     XLEN     = 32,
    parameter logic [XLEN-1:0] RESET_PC = 32'h8000_0000
) (
    input  logic            clk,
    input  logic            rst_n,
    output logic            imem_req_valid_o,
    input  logic            imem_req_ready_i,
    output logic [XLEN-1:0] imem_req_addr_o,
    input  logic            imem_resp_valid_i,
    input  logic [XLEN-1:0] imem_resp_data_i,
    output logic            inst_valid_o,
    input  logic            inst_ready_i,
    output logic [XLEN-1:0] inst_o,
    output logic [XLEN-1:0] inst_pc_o,
    input  logic            redirect_valid_i,
    input  logic [XLEN-1:0] redirect_pc_i
);

    localparam logic [1:0] StReq  = 2'd0;
    localparam logic [1:0] StWait = 2'd1;
    localparam logic [1:0] StHold = 2'd2;

    localparam logic [XLEN-1:0] AlignMask = ~{{(XLEN-2){1'b0}}, 2'b11};
    localparam logic [XLEN-1:0] PcStep    = {{(XLEN-3){1'b0}}, 3'd4};

    logic [1:0]      state_q, state_d;
    logic [XLEN-1:0] pc_q, pc_d;
    logic            kill_q, kill_d;
    logic            inst_valid_q, inst_valid_d;
    logic [XLEN-1:0] inst_q, inst_d;
    logic [XLEN-1:0] inst_pc_q, inst_pc_d;
    logic [XLEN-1:0] redirect_pc_aligned;

    assign redirect_pc_aligned = redirect_pc_i & AlignMask;

    // Valids are gated by reset so no handshake can complete on a reset cycle.
    assign imem_req_valid_o = rst_n && (state_q == StReq);
    assign imem_req_addr_o  = pc_q;
    assign inst_valid_o     = rst_n && inst_valid_q;
    assign inst_o           = inst_q;
    assign inst_pc_o        = inst_pc_q;

    always_comb begin
        state_d      = state_q;
        pc_d         = pc_q;
        kill_d       = kill_q;
        inst_valid_d = inst_valid_q;
        inst_d       = inst_q;
        inst_pc_d    = inst_pc_q;

        unique case (state_q)
            StReq: begin
                if (redirect_valid_i) begin
                    pc_d = redirect_pc_aligned;
                    if (imem_req_ready_i) begin
                        // Request already went out with the old address; discard its reply.
                        kill_d  = 1'b1;
                        state_d = StWait;
                    end
                end else if (imem_req_ready_i) begin
                    state_d = StWait;
                end
            end
            StWait: begin
                if (redirect_valid_i) begin
                    pc_d = redirect_pc_aligned;
                    if (imem_resp_valid_i) begin
                        kill_d  = 1'b0;
                        state_d = StReq;
                    end else begin
                        kill_d = 1'b1;
                    end
                end else if (imem_resp_valid_i) begin
                    if (kill_q) begin
                        kill_d  = 1'b0;
                        state_d = StReq;
                    end else begin
                        inst_d       = imem_resp_data_i;
                        inst_pc_d    = pc_q;
                        inst_valid_d = 1'b1;
                        state_d      = StHold;
                    end
                end
            end
            StHold: begin
                if (redirect_valid_i) begin
                    inst_valid_d = 1'b0;
                    pc_d         = redirect_pc_aligned;
                    state_d      = StReq;
                end else if (inst_ready_i) begin
                    inst_valid_d = 1'b0;
                    pc_d         = pc_q + PcStep;
                    state_d      = StReq;
                end
            end
            default: begin
                state_d = StReq;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q      <= StReq;
            pc_q         <= RESET_PC;
            kill_q       <= 1'b0;
            inst_valid_q <= 1'b0;
            inst_q       <= '0;
            inst_pc_q    <= '0;
        end else begin
            state_q      <= state_d;
            pc_q         <= pc_d;
            kill_q       <= kill_d;
            inst_valid_q <= inst_valid_d;
            inst_q       <= inst_d;
            inst_pc_q    <= inst_pc_d;
        end
    end

endmodule

// File: tb/tb_ifu_fetch_ctrl.sv
// Directed bench for ifu_fetch_ctrl: a per-cycle vector table followed by hand-written
// sequences for stall, held-request, mid-operation reset and PC wrap corner cases.
module tb_ifu_fetch_ctrl;

    logic        clk;
    logic        rst_n;
    logic        imem_req_valid;
    logic        imem_req_ready;
    logic [31:0] imem_req_addr;
    logic        imem_resp_valid;
    logic [31:0] imem_resp_data;
    logic        inst_valid;
    logic        inst_ready;
    logic [31:0] inst;
    logic [31:0] inst_pc;
    logic        redirect_valid;
    logic [31:0] redirect_pc;

    int n_vec;
    int n_bad;

    ifu_fetch_ctrl #(
        .XLEN     (32),
        .RESET_PC (32'h8000_0000)
    ) dut (
        .clk               (clk),
        .rst_n             (rst_n),
        .imem_req_valid_o  (imem_req_valid),
        .imem_req_ready_i  (imem_req_ready),
        .imem_req_addr_o   (imem_req_addr),
        .imem_resp_valid_i (imem_resp_valid),
        .imem_resp_data_i  (imem_resp_data),
        .inst_valid_o      (inst_valid),
        .inst_ready_i      (inst_ready),
        .inst_o            (inst),
        .inst_pc_o         (inst_pc),
        .redirect_valid_i  (redirect_valid),
        .redirect_pc_i     (redirect_pc)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Inputs driven for one cycle, plus the outputs expected during that cycle.
    typedef struct packed {
        logic        rst;
        logic        rr;
        logic        rsv;
        logic [31:0] rdata;
        logic        ir;
        logic        redir;
        logic [31:0] rpc;
        logic        e_rv;
        logic [31:0] e_addr;
        logic        e_iv;
        logic [31:0] e_inst;
        logic [31:0] e_ipc;
    } vec_t;

    localparam int NVec = 26;
    vec_t vecs [NVec];

    task automatic cyc(input logic rst, input logic rr, input logic rsv, input logic [31:0] rdata,
                       input logic ir, input logic redir, input logic [31:0] rpc);
        @(negedge clk);
        rst_n           = rst;
        imem_req_ready  = rr;
        imem_resp_valid = rsv;
        imem_resp_data  = rdata;
        inst_ready      = ir;
        redirect_valid  = redir;
        redirect_pc     = rpc;
        #1;
    endtask

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", name, got, exp);
        end
    endtask

    initial begin
        n_vec = 0;
        n_bad = 0;
        //           rst  rr   rsv  rdata          ir   rdr  rpc            rv   addr           iv   inst           ipc
        vecs[0]  = '{1'b0,1'b0,1'b0,32'h0,         1'b0,1'b0,32'h0,         1'b0,32'h8000_0000,1'b0,32'h0,         32'h0};
        vecs[1]  = '{1'b1,1'b1,1'b0,32'h0,         1'b0,1'b0,32'h0,         1'b1,32'h8000_0000,1'b0,32'h0,         32'h0};
        vecs[2]  = '{1'b1,1'b1,1'b1,32'h1111_1111, 1'b0,1'b0,32'h0,         1'b0,32'h8000_0000,1'b0,32'h0,         32'h0};
        vecs[3]  = '{1'b1,1'b0,1'b0,32'h0,         1'b1,1'b0,32'h0,         1'b0,32'h8000_0000,1'b1,32'h1111_1111, 32'h8000_0000};
        vecs[4]  = '{1'b1,1'b1,1'b0,32'h0,         1'b0,1'b0,32'h0,         1'b1,32'h8000_0004,1'b0,32'h1111_1111, 32'h8000_0000};
        vecs[5]  = '{1'b1,1'b1,1'b1,32'h2222_2222, 1'b1,1'b0,32'h0,         1'b0,32'h8000_0004,1'b0,32'h1111_1111, 32'h8000_0000};
        vecs[6]  = '{1'b1,1'b0,1'b0,32'h0,         1'b1,1'b0,32'h0,         1'b0,32'h8000_0004,1'b1,32'h2222_2222, 32'h8000_0004};
        vecs[7]  = '{1'b1,1'b1,1'b0,32'h0,         1'b0,1'b0,32'h0,         1'b1,32'h8000_0008,1'b0,32'h2222_2222, 32'h8000_0004};
        vecs[8]  = '{1'b1,1'b0,1'b1,32'h3333_3333, 1'b0,1'b0,32'h0,         1'b0,32'h8000_0008,1'b0,32'h2222_2222, 32'h8000_0004};
        vecs[9]  = '{1'b1,1'b0,1'b0,32'h0,         1'b1,1'b0,32'h0,         1'b0,32'h8000_0008,1'b1,32'h3333_3333, 32'h8000_0008};
        // Redirect while waiting: the returning word is dropped.
        vecs[10] = '{1'b1,1'b1,1'b0,32'h0,         1'b0,1'b0,32'h0,         1'b1,32'h8000_000C,1'b0,32'h3333_3333, 32'h8000_0008};
        vecs[11] = '{1'b1,1'b0,1'b0,32'h0,         1'b0,1'b1,32'h8000_0100, 1'b0,32'h8000_000C,1'b0,32'h3333_3333, 32'h8000_0008};
        vecs[12] = '{1'b1,1'b0,1'b1,32'h00F0_0093, 1'b0,1'b0,32'h0,         1'b0,32'h8000_0100,1'b0,32'h3333_3333, 32'h8000_0008};
        vecs[13] = '{1'b1,1'b0,1'b0,32'h0,         1'b0,1'b0,32'h0,         1'b1,32'h8000_0100,1'b0,32'h3333_3333, 32'h8000_0008};
        vecs[14] = '{1'b1,1'b1,1'b0,32'h0,         1'b0,1'b0,32'h0,         1'b1,32'h8000_0100,1'b0,32'h3333_3333, 32'h8000_0008};
        vecs[15] = '{1'b1,1'b0,1'b1,32'h4444_4444, 1'b0,1'b0,32'h0,         1'b0,32'h8000_0100,1'b0,32'h3333_3333, 32'h8000_0008};
        // Redirect in HOLD together with inst_ready: delivered, pc takes aligned target.
        vecs[16] = '{1'b1,1'b0,1'b0,32'h0,         1'b1,1'b1,32'h8000_0203, 1'b0,32'h8000_0100,1'b1,32'h4444_4444, 32'h8000_0100};
        vecs[17] = '{1'b1,1'b1,1'b0,32'h0,         1'b0,1'b0,32'h0,         1'b1,32'h8000_0200,1'b0,32'h4444_4444, 32'h8000_0100};
        vecs[18] = '{1'b1,1'b0,1'b1,32'h5555_5555, 1'b0,1'b0,32'h0,         1'b0,32'h8000_0200,1'b0,32'h4444_4444, 32'h8000_0100};
        vecs[19] = '{1'b1,1'b0,1'b0,32'h0,         1'b1,1'b0,32'h0,         1'b0,32'h8000_0200,1'b1,32'h5555_5555, 32'h8000_0200};
        // Redirect in REQ on an accepted request: reply killed.
        vecs[20] = '{1'b1,1'b1,1'b0,32'h0,         1'b0,1'b1,32'h8000_0300, 1'b1,32'h8000_0204,1'b0,32'h5555_5555, 32'h8000_0200};
        vecs[21] = '{1'b1,1'b0,1'b1,32'h6666_6666, 1'b0,1'b0,32'h0,         1'b0,32'h8000_0300,1'b0,32'h5555_5555, 32'h8000_0200};
        vecs[22] = '{1'b1,1'b0,1'b0,32'h0,         1'b0,1'b0,32'h0,         1'b1,32'h8000_0300,1'b0,32'h5555_5555, 32'h8000_0200};
        // Redirect coinciding with the response in WAIT.
        vecs[23] = '{1'b1,1'b1,1'b0,32'h0,         1'b0,1'b0,32'h0,         1'b1,32'h8000_0300,1'b0,32'h5555_5555, 32'h8000_0200};
        vecs[24] = '{1'b1,1'b0,1'b1,32'h7777_7777, 1'b0,1'b1,32'h8000_0400, 1'b0,32'h8000_0300,1'b0,32'h5555_5555, 32'h8000_0200};
        vecs[25] = '{1'b1,1'b0,1'b0,32'h0,         1'b0,1'b0,32'h0,         1'b1,32'h8000_0400,1'b0,32'h5555_5555, 32'h8000_0200};

        rst_n = 1'b0; imem_req_ready = 1'b0; imem_resp_valid = 1'b0; imem_resp_data = '0;
        inst_ready = 1'b0; redirect_valid = 1'b0; redirect_pc = '0;
        repeat (2) @(posedge clk);

        for (int i = 0; i < NVec; i++) begin
            cyc(vecs[i].rst, vecs[i].rr, vecs[i].rsv, vecs[i].rdata, vecs[i].ir, vecs[i].redir,
                vecs[i].rpc);
            n_vec++;
            if (imem_req_valid !== vecs[i].e_rv || imem_req_addr !== vecs[i].e_addr ||
                inst_valid !== vecs[i].e_iv || inst !== vecs[i].e_inst ||
                inst_pc !== vecs[i].e_ipc) begin
                n_bad++;
                $display("FAIL vec%0d: got rv=%b addr=%h iv=%b inst=%h pc=%h expected rv=%b addr=%h iv=%b inst=%h pc=%h",
                         i, imem_req_valid, imem_req_addr, inst_valid, inst, inst_pc,
                         vecs[i].e_rv, vecs[i].e_addr, vecs[i].e_iv, vecs[i].e_inst, vecs[i].e_ipc);
            end
        end

        // Decode stall in HOLD: outputs frozen, no new request.
        cyc(1, 1, 0, 0, 0, 0, 0);
        cyc(1, 0, 1, 32'h8888_8888, 0, 0, 0);
        for (int k = 0; k < 5; k++) begin
            cyc(1, 1, 0, 0, 0, 0, 0);
            chk("stall_iv", {31'h0, inst_valid}, 32'h1);
            chk("stall_inst", inst, 32'h8888_8888);
            chk("stall_pc", inst_pc, 32'h8000_0400);
            chk("stall_rv", {31'h0, imem_req_valid}, 32'h0);
        end
        cyc(1, 0, 0, 0, 1, 0, 0);
        cyc(1, 0, 0, 0, 0, 0, 0);
        chk("post_stall_addr", imem_req_addr, 32'h8000_0404);

        // Request held without ready; stray response pulse in REQ is ignored.
        for (int k = 0; k < 4; k++) begin
            cyc(1, 0, (k == 1), 32'hBAD0_BAD0, 0, 0, 0);
            chk("held_rv", {31'h0, imem_req_valid}, 32'h1);
            chk("held_addr", imem_req_addr, 32'h8000_0404);
            chk("held_iv", {31'h0, inst_valid}, 32'h0);
        end
        cyc(1, 1, 0, 0, 0, 0, 0);
        cyc(1, 0, 1, 32'h9999_9999, 0, 0, 0);
        cyc(1, 0, 0, 0, 1, 0, 0);
        chk("held_inst", inst, 32'h9999_9999);
        chk("held_pc", inst_pc, 32'h8000_0404);

        // Reset while waiting; late response after release ignored.
        cyc(1, 1, 0, 0, 0, 0, 0);
        cyc(0, 0, 0, 0, 0, 0, 0);
        chk("rst_rv", {31'h0, imem_req_valid}, 32'h0);
        chk("rst_iv", {31'h0, inst_valid}, 32'h0);
        cyc(1, 0, 1, 32'hDEAD_BEEF, 0, 0, 0);
        chk("rst_first_rv", {31'h0, imem_req_valid}, 32'h1);
        chk("rst_first_addr", imem_req_addr, 32'h8000_0000);
        cyc(1, 0, 0, 0, 0, 0, 0);
        chk("rst_late_iv", {31'h0, inst_valid}, 32'h0);
        chk("rst_late_inst", inst, 32'h0);
        chk("rst_late_rv", {31'h0, imem_req_valid}, 32'h1);

        // PC wrap from the top of the address space.
        cyc(1, 0, 0, 0, 0, 1, 32'hFFFF_FFFF);
        cyc(1, 1, 0, 0, 0, 0, 0);
        chk("wrap_addr", imem_req_addr, 32'hFFFF_FFFC);
        cyc(1, 0, 1, 32'hAAAA_AAAA, 0, 0, 0);
        cyc(1, 0, 0, 0, 1, 0, 0);
        chk("wrap_iv", {31'h0, inst_valid}, 32'h1);
        chk("wrap_inst_pc", inst_pc, 32'hFFFF_FFFC);
        cyc(1, 0, 0, 0, 0, 0, 0);
        chk("wrap_next_rv", {31'h0, imem_req_valid}, 32'h1);
        chk("wrap_next_addr", imem_req_addr, 32'h0000_0000);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
